sa_act_feeder: RTL and testbench

Left-edge activation feeder for the float32 systolic array. Accepts one ROWS-wide activation vector per handshake, buffers it in a small FIFO and presents it to the array's row inputs (`active_left` of column 0) with a diagonal skew: row r lags row 0 by r cycles. It also generates the array-wide PE enable and flushes the array with zero vectors at the end of each tile, so that every `out_sum` reaches the bottom edge.

---
 rtl/sa_act_feeder_if.sv | 29 ++
 rtl/sa_act_feeder.sv | 152 +++++++++++++++
 tb/tb_sa_act_feeder.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_act_feeder_if.sv
`timescale 1ns/1ps
// Upstream activation-vector stream into sa_act_feeder.
//   in_valid : producer has a vector on in_data
//   in_ready : feeder can accept a vector this cycle
//   in_data  : ROWS float32 elements, row r at [32r+31:32r]
//   in_last  : final vector of a tile, qualified by in_valid
// master = producer side, slave = feeder side.
interface sa_act_feeder_if #(
  parameter int unsigned ROWS = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [32*ROWS-1:0]   in_data;
  logic                 in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/sa_act_feeder.sv
`timescale 1ns/1ps
// Left-edge activation feeder for the float32 systolic array.
// Buffers ROWS-wide activation vectors in a small FIFO and presents them to the
// array's row inputs with a diagonal skew (row r lags row 0 by r issue cycles).
// Generates the array-wide PE enable and flushes the array with DRAIN zero
// vectors after the last vector of each tile, then pulses tile_done.
// Ports:
//   CLK       : clock, rising edge
//   RESET     : asynchronous active-low reset
//   up        : upstream vector stream (in_valid/in_ready/in_data/in_last)
//   hold      : stall; freezes pop, skew chains and drain counter
//   pe_en     : EN for every PE; high on issue cycles
//   act_out   : row r drives active_left of row r, column 0
//   tile_done : one-cycle pulse when a tile's flush completes
module sa_act_feeder #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DRAIN = 7
) (
  input  logic                CLK,
  input  logic                RESET,
  sa_act_feeder_if.slave      up,
  input  logic                hold,
  output logic                pe_en,
  output logic [32*ROWS-1:0]  act_out,
  output logic                tile_done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned DW = $clog2(DRAIN + 1);

  localparam logic [1:0] StStream = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  // FIFO storage (no reset needed: only entries below count_q are ever read)
  logic [32*ROWS-1:0] mem_data_q [DEPTH];
  logic               mem_last_q [DEPTH];

  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [1:0]         state_q, state_d;
  logic [DW-1:0]      drain_cnt_q, drain_cnt_d;
  logic [31:0]        row0_q;

  logic               fifo_empty;
  logic               push, pop, issue;
  logic [32*ROWS-1:0] issue_vec;

  assign fifo_empty  = (count_q == '0);
  // No bypass: a full FIFO refuses a push even when it pops this cycle.
  assign up.in_ready = (count_q < CW'(DEPTH));
  assign push        = up.in_valid && up.in_ready;
  assign count_d     = count_q + CW'(push) - CW'(pop);

  always_comb begin
    issue       = 1'b0;
    pop         = 1'b0;
    issue_vec   = '0;
    tile_done   = 1'b0;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      StStream: begin
        if (!hold && !fifo_empty) begin
          issue     = 1'b1;
          pop       = 1'b1;
          issue_vec = mem_data_q[rd_ptr_q];
          if (mem_last_q[rd_ptr_q]) begin
            state_d     = StDrain;
            drain_cnt_d = DW'(DRAIN);
          end
        end
      end
      StDrain: begin
        // Zero vectors push the tail of the tile through the array.
        if (!hold) begin
          issue       = 1'b1;
          drain_cnt_d = drain_cnt_q - DW'(1);
          if (drain_cnt_q == DW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        tile_done = 1'b1;
        state_d   = StStream;
      end
      default: state_d = StStream;
    endcase
  end

  assign pe_en = issue;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StStream;
      drain_cnt_q <= '0;
      row0_q      <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q     <= count_d;
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      if (issue) begin
        row0_q <= issue_vec[31:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= up.in_data;
      mem_last_q[wr_ptr_q] <= up.in_last;
    end
  end

  // Row 0 follows the issued vector directly; between issues it holds the
  // last issued value so act_out stays stable while EN is low.
  assign act_out[31:0] = issue ? issue_vec[31:0] : row0_q;

  // Row r: r-stage chain, advanced only on issue, so row r in issue cycle j
  // carries the row-r element issued in cycle j-r.
  for (genvar r = 1; r < ROWS; r++) begin : g_skew
    logic [31:0] sh_q [r];

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        for (int k = 0; k < r; k++) begin
          sh_q[k] <= '0;
        end
      end else if (issue) begin
        sh_q[0] <= issue_vec[32*r +: 32];
        for (int k = 1; k < r; k++) begin
          sh_q[k] <= sh_q[k-1];
        end
      end
    end

    assign act_out[32*r +: 32] = sh_q[r-1];
  end

endmodule

// File: tb/tb_sa_act_feeder.sv
`timescale 1ns/1ps
module tb_sa_act_feeder;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DRAIN = 7;
  localparam int unsigned W     = 32 * ROWS;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         hold  = 1'b0;
  logic         pe_en;
  logic         tile_done;
  logic [W-1:0] act_out;

  sa_act_feeder_if #(.ROWS(ROWS)) up ();

  sa_act_feeder #(
    .ROWS  (ROWS),
    .DEPTH (DEPTH),
    .DRAIN (DRAIN)
  ) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .up        (up),
    .hold      (hold),
    .pe_en     (pe_en),
    .act_out   (act_out),
    .tile_done (tile_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         last;
  } entry_t;

  // Model: buffered vectors, issued-vector history, drain bookkeeping.
  entry_t       mq[$];
  logic [W-1:0] hist[$];
  int           m_drain = 0;
  bit           m_done  = 0;
  bit           e_issue, e_td, e_ready, e_push;
  logic [W-1:0] cur, e_act;
  entry_t       ent;

  // Observations.
  logic [W-1:0] cap[$];
  int           cap_cyc[$];
  int           td_cyc[$];
  int           cyc = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // float32 bits of a small non-negative integer
  function automatic logic [31:0] fb(input int v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic logic [W-1:0] vec(input int k);
    logic [W-1:0] v;
    for (int r = 0; r < ROWS; r++) v[32*r +: 32] = fb(10 * k + r);
    return v;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mq.delete();
      hist.delete();
      m_drain = 0;
      m_done  = 0;
      check("rst_pe_en", W'(pe_en), '0);
      check("rst_tile_done", W'(tile_done), '0);
      check("rst_act_out", act_out, '0);
      check("rst_in_ready", W'(up.in_ready), W'(1));
    end else begin
      e_ready = (mq.size() < int'(DEPTH));
      e_td    = m_done;
      if (m_done) begin
        e_issue = 0;
        cur     = '0;
      end else if (m_drain > 0) begin
        e_issue = !hold;
        cur     = '0;
      end else begin
        e_issue = !hold && (mq.size() > 0);
        cur     = (mq.size() > 0) ? mq[0].d : '0;
      end
      check("pe_en", W'(pe_en), W'(e_issue));
      check("tile_done", W'(tile_done), W'(e_td));
      check("in_ready", W'(up.in_ready), W'(e_ready));
      if (e_issue) begin
        e_act = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
          if (r == 0) e_act[31:0] = cur[31:0];
          else if (hist.size() >= r) e_act[32*r +: 32] = hist[hist.size() - r][32*r +: 32];
        end
        check("act_out", act_out, e_act);
      end
      // Advance the model across the coming rising edge.
      e_push = up.in_valid && e_ready;
      if (m_done) begin
        m_done = 0;
      end else if (e_issue) begin
        if (m_drain > 0) begin
          hist.push_back('0);
          m_drain--;
          if (m_drain == 0) m_done = 1;
        end else begin
          ent = mq.pop_front();
          hist.push_back(ent.d);
          if (ent.last) m_drain = int'(DRAIN);
        end
      end
      if (e_push) begin
        ent.d    = up.in_data;
        ent.last = up.in_last;
        mq.push_back(ent);
      end
    end
    if (pe_en === 1'b1) begin
      cap.push_back(act_out);
      cap_cyc.push_back(cyc);
    end
    if (tile_done === 1'b1) td_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    up.in_valid = 1'b0;
    up.in_last  = 1'b0;
    up.in_data  = '0;
  endtask

  task automatic push_vec(input logic [W-1:0] d, input logic l);
    int n;
    bit acc;
    n = 0;
    up.in_valid = 1'b1;
    up.in_data  = d;
    up.in_last  = l;
    do begin
      @(negedge clk);
      acc = up.in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: vector %h not accepted within 200 cycles", d);
    end
  endtask

  task automatic wait_tiles(input int target, input int budget);
    int n;
    n = 0;
    while (td_cyc.size() < target && n < budget) begin
      tick();
      n++;
    end
    if (td_cyc.size() < target) begin
      checks++;
      errors++;
      $display("FAIL tile_timeout: got %0d tile_done pulses want %0d", td_cyc.size(), target);
    end
  endtask

  task automatic clear_obs();
    cap.delete();
    cap_cyc.delete();
    td_cyc.delete();
  endtask

  // Hand-computed expectations for tile v0..v3 (vk row r = float(10k+r)).
  task automatic check_tile1(input string p);
    check({p, "_issues"}, W'(cap.size()), W'(11));
    check({p, "_j1"}, cap[1], {32'h0, 32'h0, 32'h3F80_0000, 32'h4120_0000});
    check({p, "_j3"}, cap[3], {32'h4040_0000, 32'h4140_0000, 32'h41A8_0000, 32'h41F0_0000});
    check({p, "_j6"}, cap[6], {32'h4204_0000, 96'h0});
    check({p, "_j10"}, cap[10], '0);
    check({p, "_tdone_cnt"}, W'(td_cyc.size()), W'(1));
    check({p, "_tdone_cyc"}, W'(td_cyc[0]), W'(cap_cyc[10] + 1));
  endtask

  initial begin
    int n;
    logic [W-1:0] sv;
    idle();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic tile, back-to-back pushes.
    clear_obs();
    for (int k = 0; k < 4; k++) push_vec(vec(k), (k == 3));
    idle();
    wait_tiles(1, 40);
    repeat (3) tick();
    check_tile1("t1");

    // Fill under hold; fifth vector waits for a pop.
    clear_obs();
    hold = 1'b1;
    for (int k = 0; k < 4; k++) push_vec(vec(k), 1'b0);
    up.in_valid = 1'b1;
    up.in_data  = vec(4);
    up.in_last  = 1'b0;
    @(negedge clk);
    check("t2_full_ready", W'(up.in_ready), '0);
    check("t2_hold_no_issue", W'(pe_en), '0);
    tick();
    hold = 1'b0;
    push_vec(vec(4), 1'b0);
    push_vec(vec(5), 1'b1);
    idle();
    wait_tiles(1, 60);
    repeat (2) tick();
    check("t2_issues", W'(cap.size()), W'(13));
    check("t2_j4_row0", W'(cap[4][31:0]), W'(32'h4220_0000));
    check("t2_j5_row1", W'(cap[5][63:32]), W'(32'h4224_0000));

    // Hold toggling every cycle.
    clear_obs();
    fork
      begin
        for (int k = 0; k < 4; k++) push_vec(vec(k), (k == 3));
        idle();
      end
      begin
        repeat (40) begin
          hold = ~hold;
          tick();
        end
        hold = 1'b0;
      end
    join
    wait_tiles(1, 40);
    repeat (2) tick();
    check_tile1("t3");

    // Two tiles back-to-back.
    clear_obs();
    push_vec(vec(0), 1'b0);
    push_vec(vec(1), 1'b1);
    push_vec(vec(2), 1'b0);
    push_vec(vec(3), 1'b1);
    idle();
    wait_tiles(2, 80);
    repeat (2) tick();
    check("t4_issues", W'(cap.size()), W'(18));
    check("t4_b_first", cap[9], {96'h0, 32'h41A0_0000});
    check("t4_b_after_done", W'(cap_cyc[9]), W'(td_cyc[0] + 1));

    // Reset in the middle of the drain.
    clear_obs();
    push_vec(vec(1), 1'b0);
    push_vec(vec(2), 1'b1);
    idle();
    n = 0;
    while (cap.size() < 4 && n < 40) begin
      tick();
      n++;
    end
    check("t5_reached_drain", W'(cap.size() >= 4), W'(1));
    #2;
    check("t5_pre_row3", W'(act_out[127:96]), W'(32'h41B8_0000));
    rst_n = 1'b0;
    #1;
    check("t5_async_pe_en", W'(pe_en), '0);
    check("t5_async_tile_done", W'(tile_done), '0);
    check("t5_async_act_out", act_out, '0);
    tick();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("t5_no_tile_done", W'(td_cyc.size()), '0);
    check("t5_ready", W'(up.in_ready), W'(1));

    // Special float bit patterns pass unmodified.
    clear_obs();
    sv = {32'h8000_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h7FC0_0000};
    push_vec(sv, 1'b1);
    idle();
    wait_tiles(1, 30);
    repeat (2) tick();
    check("t6_issues", W'(cap.size()), W'(8));
    check("t6_row0", W'(cap[0][31:0]), W'(32'h7FC0_0000));
    check("t6_row1", W'(cap[1][63:32]), W'(32'h8000_0000));
    check("t6_row2", W'(cap[2][95:64]), W'(32'h7FC0_0000));
    check("t6_row3", W'(cap[3][127:96]), W'(32'h8000_0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
